// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types, constants and digit helpers for the countdown timer controller
package timer_pkg;

  localparam int BCD_W  = 4;
  localparam int DATA_W = 3 * BCD_W;

  localparam logic [BCD_W-1:0] SEC_TENS_MAX = 4'd5;

  localparam int SEC_UNITS_LSB = 0;
  localparam int SEC_TENS_LSB  = 4;
  localparam int MIN_LSB       = 8;

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE, DONE} state_e;

  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] v,
                                                 input logic [BCD_W-1:0]  d);
    logic [DATA_W-1:0] r;
    r[MIN_LSB +: BCD_W]       = v[SEC_TENS_LSB +: BCD_W];
    r[SEC_TENS_LSB +: BCD_W]  = v[SEC_UNITS_LSB +: BCD_W];
    r[SEC_UNITS_LSB +: BCD_W] = d;
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] clamp_tens(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v;
    if (v[SEC_TENS_LSB +: BCD_W] > SEC_TENS_MAX) r[SEC_TENS_LSB +: BCD_W] = SEC_TENS_MAX;
    return r;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divides clk by TICK_DIV while run is high; tick is suppressed when zero is set
module tick_prescaler #(
  parameter int TICK_DIV = 100,
  parameter int TICK_W   = 7
) (
  input  logic clk,
  input  logic clrn,
  input  logic run,
  input  logic zero,
  output logic tick
);

  localparam logic [TICK_W-1:0] LAST = TICK_W'(TICK_DIV - 1);

  logic [TICK_W-1:0] count_q, count_d;
  logic              tick_q, tick_d;

  // The count only advances while run is high, so a pause keeps the tick phase.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (run) begin
      if (count_q == LAST) begin
        count_d = '0;
        tick_d  = !zero;
      end else begin
        count_d = count_q + TICK_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - countdown timer controller: keypad entry, load, run/pause/clear, completion
// Optional DOOR_INTERLOCK_EN adds a door_open input that pauses RUN and blocks start.
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 100,
  parameter int TICK_W   = 7
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              key_valid,
  input  logic [BCD_W-1:0]  key_digit,
  input  logic              start,
  input  logic              stop,
  input  logic              clear,
  input  logic              cnt_zero,
`ifdef DOOR_INTERLOCK_EN
  input  logic              door_open,
`endif
  output logic [DATA_W-1:0] cnt_data,
  output logic              cnt_loadn,
  output logic              cnt_clrn,
  output logic              cnt_en,
  output logic              running,
  output logic              done
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] entry_q, entry_d, cnt_data_q, cnt_data_d;
  logic              cnt_loadn_q, cnt_loadn_d, cnt_clrn_q, cnt_clrn_d;
  logic              running_q, running_d, done_q, done_d;
  logic              door, key_ok, go, abort;

`ifdef DOOR_INTERLOCK_EN
  assign door = door_open;
`else
  assign door = 1'b0;
`endif

  assign key_ok = key_valid && (key_digit <= 4'd9);
  assign go     = start && !door;

  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_data_d = cnt_data_q;
    abort      = 1'b0;
    unique case (state_q)
      IDLE:  if (key_ok) begin
               state_d = ENTRY;
               entry_d = shift_in(entry_q, key_digit);
             end
      ENTRY: if (clear)       state_d = IDLE;
             else if (go)     state_d = (entry_q != '0) ? LOAD : IDLE;
             else if (key_ok) entry_d = shift_in(entry_q, key_digit);
      LOAD:  state_d = RUN;
      // A zeroed chain finishes before any pause request is honoured.
      RUN:   if (clear) begin
               state_d = IDLE;
               abort   = 1'b1;
             end else if (cnt_zero)     state_d = DONE;
             else if (stop || door)     state_d = PAUSE;
      PAUSE: if (clear) begin
               state_d = IDLE;
               abort   = 1'b1;
             end else if (go) state_d = RUN;
      DONE:  if (clear) begin
               state_d = IDLE;
               abort   = 1'b1;
             end else if (start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_d == IDLE) entry_d = '0;
    if (state_d == LOAD) cnt_data_d = clamp_tens(entry_q);
    cnt_loadn_d = (state_d != LOAD);
    cnt_clrn_d  = !abort;
    running_d   = (state_d == RUN);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q     <= IDLE;
      entry_q     <= '0;
      cnt_data_q  <= '0;
      cnt_loadn_q <= 1'b1;
      cnt_clrn_q  <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      cnt_data_q  <= cnt_data_d;
      cnt_loadn_q <= cnt_loadn_d;
      cnt_clrn_q  <= cnt_clrn_d;
      running_q   <= running_d;
      done_q      <= done_d;
    end
  end

  // The prescaler restarts from zero on the edge that enters LOAD.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .TICK_W   (TICK_W)
  ) u_prescaler (
    .clk  (clk),
    .clrn (clrn && (state_d != LOAD)),
    .run  (state_d == RUN),
    .zero (cnt_zero),
    .tick (cnt_en)
  );

  assign cnt_data  = cnt_data_q;
  assign cnt_loadn = cnt_loadn_q;
  assign cnt_clrn  = cnt_clrn_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule
